// File: rtl/module23_stream_rx.sv
// rtl/module23_stream_rx.sv - Module23 stream receiver: ready/valid word FIFO with XOR checksum and word counter
module module23_stream_rx #(
    parameter int Width    = 10,
    parameter int Depth    = 4,
    parameter int TagWidth = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_valid,
    output logic                       o_ready,
    input  logic [Width-1:0]           i_data,
`ifdef DEFINE_A
    input  logic [TagWidth-1:0]        i_tag,
    output logic [TagWidth-1:0]        o_tag,
`endif
    output logic                       o_valid,
    input  logic                       i_ready,
    output logic [Width-1:0]           o_data,
    output logic [$clog2(Depth+1)-1:0] o_count,
    input  logic                       i_clear,
    output logic [Width-1:0]           o_checksum,
    output logic [15:0]                o_words
);
    localparam int CW = $clog2(Depth + 1);
    localparam int PW = $clog2(Depth);

    logic [Width-1:0] mem_q [Depth];
    logic [Width-1:0] mem_d [Depth];
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic [Width-1:0] checksum_q, checksum_d;
    logic [15:0]      words_q, words_d;
    logic             push, pop;

`ifdef DEFINE_A
    logic [TagWidth-1:0] tag_mem_q [Depth];
    logic [TagWidth-1:0] tag_mem_d [Depth];
`endif

    // Ready depends on occupancy only, so a full FIFO refuses even when a pop is pending.
    assign o_ready    = (count_q != CW'(Depth));
    assign o_valid    = (count_q != '0);
    assign o_data     = mem_q[rd_ptr_q];
    assign o_count    = count_q;
    assign o_checksum = checksum_q;
    assign o_words    = words_q;
    assign push       = i_valid && o_ready;
    assign pop        = o_valid && i_ready;

`ifdef DEFINE_A
    assign o_tag = tag_mem_q[rd_ptr_q];
`endif

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        checksum_d = checksum_q;
        words_d    = words_q;
`ifdef DEFINE_A
        tag_mem_d  = tag_mem_q;
`endif
        if (push) begin
            mem_d[wr_ptr_q] = i_data;
`ifdef DEFINE_A
            tag_mem_d[wr_ptr_q] = i_tag;
`endif
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        // Clear takes priority: a push on the clearing edge is not counted.
        if (i_clear) begin
            checksum_d = '0;
            words_d    = '0;
        end else if (push) begin
            checksum_d = checksum_q ^ i_data;
            if (words_q != 16'hFFFF) begin
                words_d = words_q + 16'd1;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int i = 0; i < Depth; i++) begin
                mem_q[i] <= '0;
`ifdef DEFINE_A
                tag_mem_q[i] <= '0;
`endif
            end
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            checksum_q <= '0;
            words_q    <= '0;
        end else begin
            mem_q      <= mem_d;
`ifdef DEFINE_A
            tag_mem_q  <= tag_mem_d;
`endif
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            checksum_q <= checksum_d;
            words_q    <= words_d;
        end
    end
endmodule

// File: tb/tb_module23_stream_rx.sv
// tb/tb_module23_stream_rx.sv - Bench for module23_stream_rx: directed cases plus randomized traffic against a queue model
module tb_module23_stream_rx;
    localparam int Width    = 10;
    localparam int Depth    = 4;
    localparam int TagWidth = 2;

    logic                i_clk = 1'b0;
    logic                i_rst = 1'b0;
    logic                i_valid = 1'b0;
    logic                o_ready;
    logic [Width-1:0]    i_data = '0;
    logic                o_valid;
    logic                i_ready = 1'b0;
    logic [Width-1:0]    o_data;
    logic [2:0]          o_count;
    logic                i_clear = 1'b0;
    logic [Width-1:0]    o_checksum;
    logic [15:0]         o_words;
`ifdef DEFINE_A
    logic [TagWidth-1:0] i_tag = '0;
    logic [TagWidth-1:0] o_tag;
`endif

    int checks = 0;
    int errors = 0;

    module23_stream_rx #(.Width(Width), .Depth(Depth), .TagWidth(TagWidth)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_data     (i_data),
`ifdef DEFINE_A
        .i_tag      (i_tag),
        .o_tag      (o_tag),
`endif
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_data     (o_data),
        .o_count    (o_count),
        .i_clear    (i_clear),
        .o_checksum (o_checksum),
        .o_words    (o_words)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic do_reset();
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_clear = 1'b0;
        i_rst   = 1'b0;
        tick();
        i_rst   = 1'b1;
    endtask

    int unsigned       exp_q[$];
`ifdef DEFINE_A
    int unsigned       tag_q[$];
`endif
    int unsigned       m_cs;
    int unsigned       m_words;
    bit                m_push, m_pop;

    initial begin
        // Reset state
        i_rst = 1'b0;
        #3;
        check("rst_valid", 32'(o_valid), 0);
        check("rst_count", 32'(o_count), 0);
        check("rst_ready", 32'(o_ready), 1);
        check("rst_data", 32'(o_data), 0);
        check("rst_cs", 32'(o_checksum), 0);
        check("rst_words", 32'(o_words), 0);
        tick();
        i_rst = 1'b1;

        // Single push, held downstream
        i_valid = 1'b1; i_data = 10'h155; i_ready = 1'b0;
        tick();
        i_valid = 1'b0;
        check("t1_valid", 32'(o_valid), 1);
        check("t1_data", 32'(o_data), 32'h155);
        check("t1_count", 32'(o_count), 1);
        check("t1_cs", 32'(o_checksum), 32'h155);
        check("t1_words", 32'(o_words), 1);

        // Fill to full, fifth word refused, then drain in order
        do_reset();
        for (int k = 1; k <= 4; k++) begin
            i_valid = 1'b1; i_data = 10'(k);
            tick();
        end
        check("t2_full_count", 32'(o_count), 4);
        check("t2_full_ready", 32'(o_ready), 0);
        i_data = 10'd5; i_ready = 1'b1;
        tick();
        check("t2_full_pop_count", 32'(o_count), 3);
        check("t2_words_no5", 32'(o_words), 4);
        i_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            check("t2_drain_data", 32'(o_data), 32'(k));
            tick();
        end
        check("t2_empty", 32'(o_valid), 0);
        check("t2_cs", 32'(o_checksum), 32'h004);

        // Steady push+pop at occupancy 1
        do_reset();
        i_valid = 1'b1; i_data = 10'h100;
        tick();
        i_ready = 1'b1;
        for (int k = 0; k < 20; k++) begin
            i_data = 10'(k + 1);
            check("t3_head", 32'(o_data), (k == 0) ? 32'h100 : 32'(k));
            tick();
            check("t3_count", 32'(o_count), 1);
        end
        check("t3_last", 32'(o_data), 20);
        check("t3_words", 32'(o_words), 21);

        // Clear on same edge as push
        do_reset();
        i_valid = 1'b1; i_data = 10'h0F0;
        tick();
        i_data = 10'h3FF; i_clear = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0; i_clear = 1'b0;
        check("t4_cs", 32'(o_checksum), 0);
        check("t4_words", 32'(o_words), 0);
        check("t4_data", 32'(o_data), 32'h3FF);
        check("t4_count", 32'(o_count), 1);

        // Async reset with three words buffered
        do_reset();
        i_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            i_data = 10'(k + 7);
            tick();
        end
        i_valid = 1'b0;
        #2;
        i_rst = 1'b0;
        #1;
        check("t5_valid", 32'(o_valid), 0);
        check("t5_count", 32'(o_count), 0);
        check("t5_ready", 32'(o_ready), 1);
        check("t5_words", 32'(o_words), 0);
        check("t5_cs", 32'(o_checksum), 0);
        tick();
        i_rst = 1'b1;

`ifdef DEFINE_A
        i_valid = 1'b1; i_data = 10'h0AA; i_tag = 2'b10;
        tick();
        i_valid = 1'b0;
        check("t6_tag", 32'(o_tag), 32'h2);
        check("t6_data", 32'(o_data), 32'h0AA);
`endif

        // Randomized traffic against a queue model
        do_reset();
        exp_q.delete();
`ifdef DEFINE_A
        tag_q.delete();
`endif
        m_cs = 0;
        m_words = 0;
        for (int c = 0; c < 400; c++) begin
            i_valid = ($urandom_range(0, 3) != 0);
            i_ready = ($urandom_range(0, 2) != 0);
            i_clear = ($urandom_range(0, 15) == 0);
            i_data  = 10'($urandom);
`ifdef DEFINE_A
            i_tag   = TagWidth'($urandom);
`endif
            check("rnd_count", 32'(o_count), 32'(exp_q.size()));
            check("rnd_valid", 32'(o_valid), 32'(exp_q.size() != 0));
            check("rnd_ready", 32'(o_ready), 32'(exp_q.size() < Depth));
            check("rnd_cs", 32'(o_checksum), m_cs);
            check("rnd_words", 32'(o_words), m_words);
            if (exp_q.size() != 0) begin
                check("rnd_data", 32'(o_data), exp_q[0]);
`ifdef DEFINE_A
                check("rnd_tag", 32'(o_tag), tag_q[0]);
`endif
            end
            m_push = i_valid && (exp_q.size() < Depth);
            m_pop  = i_ready && (exp_q.size() != 0);
            if (m_pop) begin
                void'(exp_q.pop_front());
`ifdef DEFINE_A
                void'(tag_q.pop_front());
`endif
            end
            if (m_push) begin
                exp_q.push_back(32'(i_data));
`ifdef DEFINE_A
                tag_q.push_back(32'(i_tag));
`endif
            end
            if (i_clear) begin
                m_cs = 0;
                m_words = 0;
            end else if (m_push) begin
                m_cs = m_cs ^ 32'(i_data);
                if (m_words < 65535) m_words++;
            end
            tick();
        end

        // Word counter saturation
        do_reset();
        i_valid = 1'b1; i_ready = 1'b1; i_data = 10'h001;
        for (int c = 0; c < 65540; c++) tick();
        i_valid = 1'b0;
        check("sat_words", 32'(o_words), 32'hFFFF);
        check("sat_count", 32'(o_count), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
